// File: rtl/compositor_pkg.sv
// compositor_pkg: shared types, fixed ROM addresses and the default palette for layer_compositor
package compositor_pkg;
   typedef logic [23:0] rgb_t;
   localparam int BLANK_ADDR_DEF   = 1706;
   localparam int TERRAIN_ADDR_DEF = 1705;
   localparam int DEFAULT_ADDR_DEF = 1704;
   localparam rgb_t DEFAULT_PAL [32] = '{
      24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'h2FBDA1,
      24'h800080, 24'h8B4513, 24'h0A0A0A, 24'hA0A0A0, 24'hFFA500, 24'hC0C0C0, 24'h404040, 24'h008000,
      24'h87CEEB, 24'h4682B4, 24'hD2B48C, 24'hF5DEB3, 24'hDC143C, 24'hFF69B4, 24'h7FFF00, 24'h228B22,
      24'h1E90FF, 24'hB22222, 24'hDAA520, 24'hADFF2F, 24'h4B0082, 24'hF0E68C, 24'hE6E6FA, 24'h708090
   };
   // Entries beyond the 32-colour table default to green.
   function automatic rgb_t default_rgb(input int i);
      return (i < 32) ? DEFAULT_PAL[i[4:0]] : 24'h00FF00;
   endfunction
endpackage

// File: rtl/layer_compositor_if.sv
// layer_compositor_if: palette write port
//   pal_we/pal_idx/pal_rgb : write request (master -> slave)
//   pal_ack                : write accepted, one cycle after pal_we (slave -> master)
interface layer_compositor_if #(parameter int PAL_W = 5);
   logic             pal_we;
   logic [PAL_W-1:0] pal_idx;
   logic [23:0]      pal_rgb;
   logic             pal_ack;
   modport master (output pal_we, pal_idx, pal_rgb, input pal_ack);
   modport slave  (input pal_we, pal_idx, pal_rgb, output pal_ack);
endinterface

// File: rtl/palette_lut.sv
// palette_lut: palette storage with registered lookup and optional write port (PALETTE_WR_EN)
//   clk, rst, rd_idx in; rgb registered colour; wr palette write slave
module palette_lut import compositor_pkg::*; #(
   parameter int PAL_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PAL_W-1:0] rd_idx,
   output rgb_t             rgb,
   layer_compositor_if.slave wr
);
`ifdef PALETTE_WR_EN
   rgb_t pal [2**PAL_W];
   // The lookup reads the array before this edge's write lands, so a same-index
   // write shows the old colour this cycle and the new one from the next.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**PAL_W; i++) pal[i] <= default_rgb(i);
         rgb        <= '0;
         wr.pal_ack <= 1'b0;
      end else begin
         if (wr.pal_we) pal[wr.pal_idx] <= wr.pal_rgb;
         rgb        <= pal[rd_idx];
         wr.pal_ack <= wr.pal_we;
      end
   end
`else
   logic unused_wr;
   assign unused_wr  = ^{wr.pal_we, wr.pal_idx, wr.pal_rgb};
   assign wr.pal_ack = 1'b0;
   always_ff @(posedge clk) rgb <= rst ? '0 : default_rgb(int'(rd_idx));
`endif
endmodule

// File: rtl/spriteROM.sv
// spriteROM: synchronous sprite ROM, one-cycle read; the colour index is the low address bits
//   clk, read_address in; data_Out registered palette index
module spriteROM #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 5
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] read_address,
   output logic [DATA_W-1:0] data_Out
);
   logic unused_hi;
   assign unused_hi = ^read_address[ADDR_W-1:DATA_W];
   always_ff @(posedge clk) data_Out <= read_address[DATA_W-1:0];
endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: 3-stage priority mux of sprite layers and terrain -> sprite ROM -> palette RGB
//   clk, Reset (sync, active high); DrawY/terrain_data terrain hit; layer_addr/layer_draw/layer_mask
//   per-layer inputs; terrain_layer terrain priority slot; frame_start loads the mask; blank (0 = blanking)
//   pal palette write slave; Red/Green/Blue, blank_out 3 clk after the inputs
//   Macro PALETTE_WR_EN makes the palette writable.
module layer_compositor import compositor_pkg::*; #(
   parameter int NUM_LAYERS   = 4,
   parameter int ADDR_W       = 18,
   parameter int PAL_W        = 5,
   parameter int V_RES        = 480,
   parameter int BLANK_ADDR   = BLANK_ADDR_DEF,
   parameter int TERRAIN_ADDR = TERRAIN_ADDR_DEF,
   parameter int DEFAULT_ADDR = DEFAULT_ADDR_DEF
) (
   input  logic                         clk,
   input  logic                         Reset,
   input  logic [9:0]                   DrawY,
   input  logic [V_RES-1:0]             terrain_data,
   input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
   input  logic [NUM_LAYERS-1:0]        layer_draw,
   input  logic [2:0]                   terrain_layer,
   input  logic [NUM_LAYERS-1:0]        layer_mask,
   input  logic                         frame_start,
   input  logic                         blank,
   layer_compositor_if.slave            pal,
   output logic [7:0]                   Red,
   output logic [7:0]                   Green,
   output logic [7:0]                   Blue,
   output logic                         blank_out
);
   logic [NUM_LAYERS-1:0] act_mask;
   logic [NUM_LAYERS-1:0] act;
   logic [ADDR_W-1:0]     sel_addr;
   logic [ADDR_W-1:0]     rom_addr;
   logic [PAL_W-1:0]      pix_idx;
   logic [2:0]            blank_d;
   logic                  terr;
   rgb_t                  rgb;
   // Shift instead of index so scan lines beyond the column read as no terrain.
   assign terr = 1'(terrain_data >> DrawY);
   assign act  = layer_draw & act_mask;
   // Walk from lowest to highest priority; terrain sits just above layer terrain_layer.
   always_comb begin
      sel_addr = (terr && int'(terrain_layer) >= NUM_LAYERS) ? ADDR_W'(TERRAIN_ADDR) : ADDR_W'(DEFAULT_ADDR);
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         sel_addr = act[i] ? layer_addr[i*ADDR_W +: ADDR_W] : sel_addr;
         sel_addr = (terr && int'(terrain_layer) == i) ? ADDR_W'(TERRAIN_ADDR) : sel_addr;
      end
      sel_addr = blank ? sel_addr : ADDR_W'(BLANK_ADDR);
   end
   always_ff @(posedge clk) begin
      if (Reset) begin
         act_mask <= '1;
         rom_addr <= ADDR_W'(BLANK_ADDR);
         blank_d  <= '0;
      end else begin
         act_mask <= frame_start ? layer_mask : act_mask;
         rom_addr <= sel_addr;
         blank_d  <= {blank_d[1:0], blank};
      end
   end
   assign blank_out = blank_d[2];
   spriteROM #(.ADDR_W(ADDR_W), .DATA_W(PAL_W)) rom (
      .clk          (clk),
      .read_address (rom_addr),
      .data_Out     (pix_idx)
   );
   palette_lut #(.PAL_W(PAL_W)) lut (
      .clk    (clk),
      .rst    (Reset),
      .rd_idx (pix_idx),
      .rgb    (rgb),
      .wr     (pal)
   );
   assign {Red, Green, Blue} = rgb;
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: scoreboard bench for layer_compositor against a priority-search reference model
module tb_layer_compositor;
   localparam int N  = 4;
   localparam int AW = 18;
   localparam int PW = 5;
   localparam int VR = 480;
   typedef struct { int due; logic [23:0] rgb; logic bo; } exp_t;
   logic          clk = 1'b0;
   logic          Reset;
   logic [9:0]    DrawY;
   logic [VR-1:0] terrain_data;
   logic [N*AW-1:0] layer_addr;
   logic [N-1:0]  layer_draw;
   logic [2:0]    terrain_layer;
   logic [N-1:0]  layer_mask;
   logic          frame_start;
   logic          blank;
   logic [7:0]    Red, Green, Blue;
   logic          blank_out;
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   exp_t          q[$];
   logic [N-1:0]  mask_m;
   logic [23:0]   pal_m [32];
   logic          ack_exp;
   logic [23:0]   def_pal [32] = '{
      24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'h2FBDA1,
      24'h800080, 24'h8B4513, 24'h0A0A0A, 24'hA0A0A0, 24'hFFA500, 24'hC0C0C0, 24'h404040, 24'h008000,
      24'h87CEEB, 24'h4682B4, 24'hD2B48C, 24'hF5DEB3, 24'hDC143C, 24'hFF69B4, 24'h7FFF00, 24'h228B22,
      24'h1E90FF, 24'hB22222, 24'hDAA520, 24'hADFF2F, 24'h4B0082, 24'hF0E68C, 24'hE6E6FA, 24'h708090
   };
   layer_compositor_if #(.PAL_W(PW)) pal_bus ();
   layer_compositor dut (
      .clk           (clk),
      .Reset         (Reset),
      .DrawY         (DrawY),
      .terrain_data  (terrain_data),
      .layer_addr    (layer_addr),
      .layer_draw    (layer_draw),
      .terrain_layer (terrain_layer),
      .layer_mask    (layer_mask),
      .frame_start   (frame_start),
      .blank         (blank),
      .pal           (pal_bus),
      .Red           (Red),
      .Green         (Green),
      .Blue          (Blue),
      .blank_out     (blank_out)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   // Reference: scan priority slots top-down; terrain occupies slot terrain_layer.
   function automatic logic [AW-1:0] ref_addr();
      int   y;
      logic t;
      y = int'(DrawY);
      t = (y < VR) ? terrain_data[y[8:0]] : 1'b0;
      if (!blank) return AW'(1706);
      for (int i = 0; i < N; i++) begin
         if (t && int'(terrain_layer) == i) return AW'(1705);
         if (layer_draw[i] && mask_m[i]) return layer_addr[i*AW +: AW];
      end
      return t ? AW'(1705) : AW'(1704);
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic issue();
      logic [AW-1:0] a;
      exp_t e;
      a     = ref_addr();
      e.due = cyc + 3;
      e.rgb = pal_m[a[4:0]];
      e.bo  = blank;
      q.push_back(e);
      if (frame_start) mask_m = layer_mask;
      tick();
   endtask
   task automatic set_layers();
      for (int i = 0; i < N; i++) layer_addr[i*AW +: AW] = {13'($urandom), 5'(20 + i)};
   endtask
   task automatic model_reset();
      mask_m = '1;
      for (int i = 0; i < 32; i++) pal_m[i] = def_pal[i];
   endtask
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         chk("rgb", {8'h0, Red, Green, Blue}, {8'h0, e.rgb});
         chk("blank_out", {31'h0, blank_out}, {31'h0, e.bo});
      end
   end
   initial begin
`ifdef PALETTE_WR_EN
      ack_exp = 1'b1;
`else
      ack_exp = 1'b0;
`endif
      model_reset();
      Reset = 1'b1; DrawY = 10'd100; terrain_data = '0; layer_addr = '0; layer_draw = '0;
      terrain_layer = 3'd0; layer_mask = '1; frame_start = 1'b0; blank = 1'b1;
      pal_bus.pal_we = 1'b1; pal_bus.pal_idx = 5'd7; pal_bus.pal_rgb = 24'hABCDEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_rgb", {8'h0, Red, Green, Blue}, 32'h0);
         chk("reset_blank_out", {31'h0, blank_out}, 32'h0);
         chk("reset_ack", {31'h0, pal_bus.pal_ack}, 32'h0);
      end
      Reset = 1'b0; pal_bus.pal_we = 1'b0;
      issue();
      chk("ack_after_reset_we", {31'h0, pal_bus.pal_ack}, 32'h0);
      set_layers();
      terrain_data[100] = 1'b1;
      layer_draw = 4'b0110; terrain_layer = 3'd1; issue();
      terrain_layer = 3'd0; issue();
      terrain_layer = 3'd4; issue();
      terrain_layer = 3'd7; issue();
      layer_draw = 4'b0000; terrain_layer = 3'd5; issue();
      DrawY = 10'd700; issue();
      DrawY = 10'd100; layer_draw = 4'b1111; terrain_layer = 3'd3; issue();
      blank = 1'b0; issue();
      frame_start = 1'b1; layer_mask = 4'b1111; issue();
      frame_start = 1'b0; blank = 1'b1; terrain_data = '0; layer_draw = 4'b0110; issue();
      layer_mask = 4'b1101; issue();
      issue();
      blank = 1'b0; frame_start = 1'b1; issue();
      frame_start = 1'b0; blank = 1'b1; issue();
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < N; i++) layer_addr[i*AW +: AW] = AW'($urandom);
         for (int i = 0; i < VR; i += 32) terrain_data[i +: 32] = $urandom;
         layer_draw    = N'($urandom);
         layer_mask    = N'($urandom);
         terrain_layer = 3'($urandom);
         DrawY         = 10'($urandom_range(0, 599));
         frame_start   = ($urandom_range(0, 15) == 0);
         blank         = frame_start ? 1'b0 : ($urandom_range(0, 7) != 0);
         issue();
      end
      frame_start = 1'b1; blank = 1'b0; layer_mask = '1; issue();
      frame_start = 1'b0; blank = 1'b1; terrain_data = '0; layer_draw = 4'b0001;
      layer_addr[0 +: AW] = {13'h5, 5'd7};
      issue();
`ifdef PALETTE_WR_EN
      pal_m[7] = 24'h123456;
`endif
      issue();
      pal_bus.pal_we = 1'b1; pal_bus.pal_idx = 5'd7; pal_bus.pal_rgb = 24'h123456;
      issue();
      chk("pal_ack_pulse", {31'h0, pal_bus.pal_ack}, {31'h0, ack_exp});
      pal_bus.pal_we = 1'b0;
      issue();
      chk("pal_ack_clear", {31'h0, pal_bus.pal_ack}, 32'h0);
      frame_start = 1'b1; blank = 1'b0; layer_mask = '0; issue();
      frame_start = 1'b0; blank = 1'b1; issue();
      repeat (4) tick();
      Reset = 1'b1;
      q.delete();
      tick();
      chk("midreset_rgb", {8'h0, Red, Green, Blue}, 32'h0);
      chk("midreset_blank_out", {31'h0, blank_out}, 32'h0);
      chk("midreset_ack", {31'h0, pal_bus.pal_ack}, 32'h0);
      Reset = 1'b0;
      model_reset();
      issue();
      issue();
      repeat (5) tick();
      chk("queue_drained", q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
